usram_fifo_ctrl: RTL and testbench

- Single-clock synchronous FIFO controller that acts as the initiator for one μSRAM block.
- Drives the μSRAM write port (we/addr/din) and one synchronous read port (addr, registered dout with 1-cycle latency).
- Exposes valid/ready push and pop streams; the pop side is first-word-fall-through through a 2-entry output stage.
- Used wherever a small elastic buffer is needed in front of or behind fabric logic; the μSRAM instance sits beside it in the parent.

---
 rtl/usram_fifo_ctrl.sv | 99 +++++++++
 tb/tb_usram_fifo_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usram_fifo_ctrl.sv
// Valid/ready FIFO controller driving one uSRAM (1-cycle registered read) with a 2-entry FWFT output stage.
// Push-to-pop latency 3 cycles; s_ready drops when the RAM holds DEPTH words, m_valid drops when the output stage is empty.
module usram_fifo_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = $clog2(2**ADDR_WIDTH+3)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d, occ_after;
  logic [DATA_WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic                  push, pop, issue;
  logic [2:0]            pend;

  // RAM is full exactly when the MSB of the DEPTH-range counter is set.
  assign s_ready   = resetn & ~ram_cnt_q[ADDR_WIDTH];
  assign full      = ~s_ready;
  assign push      = s_valid & s_ready;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = out_q;
  assign pop       = m_valid & m_ready;
  assign occ_after = occ_q - {1'b0, pop};
  assign pend      = {1'b0, occ_after} + {2'b00, inflight_q};
  assign issue     = (ram_cnt_q != '0) & (pend < 3'd2);

  assign ram_we    = push;
  assign ram_waddr = wr_ptr_q;
  assign ram_wdata = s_data;
  assign ram_raddr = rd_ptr_q;

  assign count = CNT_WIDTH'(ram_cnt_q) + CNT_WIDTH'(inflight_q) + CNT_WIDTH'(occ_q);
  assign empty = (count == '0);

  always_comb begin
    wr_ptr_d   = push  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    if (push && !issue)
      ram_cnt_d = ram_cnt_q + CNT_ONE;
    else if (!push && issue)
      ram_cnt_d = ram_cnt_q - CNT_ONE;
    inflight_d = issue;
    occ_d      = occ_after + {1'b0, inflight_q};
    out_d      = out_q;
    skid_d     = skid_q;
    if (pop && occ_q == 2'd2)
      out_d = skid_q;
    // Returning word lands in the head slot only if the head is free after this cycle's pop.
    if (inflight_q) begin
      if (occ_after == 2'd0)
        out_d = ram_rdata;
      else
        skid_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_usram_fifo_ctrl.sv
// Randomized and directed checks of usram_fifo_ctrl against a queue-based reference model and a behavioural uSRAM.
module tb_usram_fifo_ctrl;
  localparam int DW    = 18;
  localparam int AW    = 6;
  localparam int DEPTH = 2**AW;
  localparam int CW    = $clog2(DEPTH+3);

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [CW-1:0] count;
  logic          empty, full, ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;

  usram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .empty(empty), .full(full),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=progress t=%0t", name, $time);
  endtask

  // Reference model: word queue plus how many words sit in RAM, in the read pipe and in the output stage.
  logic [DW-1:0] q[$];
  int n_ram = 0, n_fly = 0, n_out = 0, wptr = 0, rptr = 0;
  logic [DW-1:0] last_head = '0;

  always @(negedge clk) begin
    bit exp_rdy, mpush, mpop, missue;
    logic [DW-1:0] exp_md;
    if (!resetn) begin
      q.delete();
      n_ram = 0; n_fly = 0; n_out = 0; wptr = 0; rptr = 0; last_head = '0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 1);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_raddr", ram_raddr, 0);
    end else begin
      exp_rdy = (n_ram < DEPTH);
      mpush   = s_valid && exp_rdy;
      mpop    = (n_out > 0) && m_ready;
      missue  = (n_ram > 0) && (n_out + n_fly - int'(mpop) < 2);
      exp_md  = (n_out > 0) ? q[0] : last_head;
      chk("s_ready", s_ready, exp_rdy);
      chk("full", full, !exp_rdy);
      chk("m_valid", m_valid, n_out > 0);
      chk("m_data", m_data, exp_md);
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("ram_we", ram_we, mpush);
      chk("ram_waddr", ram_waddr, wptr % DEPTH);
      chk("ram_raddr", ram_raddr, rptr % DEPTH);
      if (mpush) chk("ram_wdata", ram_wdata, s_data);
      if (mpush && missue) chk("collision", ram_waddr == ram_raddr, 0);
      if (n_out > 0) last_head = q[0];
      if (mpush) begin q.push_back(s_data); wptr++; end
      if (mpop) void'(q.pop_front());
      n_ram = n_ram + int'(mpush) - int'(missue);
      n_out = n_out - int'(mpop) + n_fly;
      n_fly = int'(missue);
      if (missue) rptr++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    logic acc;
    s_data  = d;
    s_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      acc = s_ready;
      step();
      if (acc) begin
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    timeout_fail("push_accept");
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (count == 0) begin
        m_ready = 1'b0;
        return;
      end
      step();
    end
    m_ready = 1'b0;
    timeout_fail("drain");
  endtask

  initial begin
    logic acc;
    int pushes, popcnt;
    resetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    step(); step(); step();
    chk("init_count", count, 0);
    chk("init_full", full, 1);
    resetn = 1'b1;
    step();
    chk("init_s_ready", s_ready, 1);

    // Single word: push in cycle 0, visible in cycle 3.
    s_data = 18'h2A5A5; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk("single_c2_valid", m_valid, 0);
    chk("single_c2_count", count, 1);
    step();
    chk("single_c3_valid", m_valid, 1);
    chk("single_c3_data", m_data, 18'h2A5A5);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("single_empty", empty, 1);
    chk("single_count", count, 0);

    // Fill to DEPTH+2 with the sink stalled.
    for (int i = 0; i < DEPTH + 2; i++) push_word(DW'(i));
    chk("fill_s_ready", s_ready, 0);
    s_data = 18'h00099; s_valid = 1'b1;
    step(); step();
    chk("fill_count", count, DEPTH + 2);
    chk("fill_full", full, 1);
    chk("fill_no_we", ram_we, 0);
    drain();
    chk("fill_drained", count, 0);
    chk("fill_last_data", m_data, 65);

    // Continuous streaming across several pointer wraps.
    pushes = 0; popcnt = 0;
    s_data = 18'd1000; s_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 320; c++) begin
      acc = s_valid && s_ready;
      if (c >= 20 && c < 220 && m_valid && m_ready) popcnt++;
      if (c == 100) chk("stream_count", count, 3);
      step();
      if (acc) begin
        pushes++;
        s_data = s_data + 1'b1;
        if (pushes == 300) s_valid = 1'b0;
      end
    end
    chk("stream_rate", popcnt, 200);
    drain();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      step();
    end
    drain();

    // Reset mid-stream with a read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 21; i++) push_word(DW'(500 + i));
    step(); step(); step(); step(); step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("mid_count", count, 20);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", count, 0);
    step(); step();
    resetn = 1'b1;
    s_data = 18'h00001; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk("post_rst_c2_valid", m_valid, 0);
    step();
    chk("post_rst_c3_valid", m_valid, 1);
    chk("post_rst_c3_data", m_data, 18'h00001);
    drain();

    // Pop at full while pushing: push blocked that cycle, reopens once RAM has space.
    for (int i = 0; i < DEPTH + 2; i++) push_word(DW'(700 + i));
    chk("full2_count", count, DEPTH + 2);
    s_data = 18'd900; s_valid = 1'b1; m_ready = 1'b1;
    chk("full2_pop_cycle_ready", s_ready, 0);
    step();
    m_ready = 1'b0;
    chk("full2_after_pop_ready", s_ready, 1);
    step();
    s_valid = 1'b0;
    chk("full2_refill_count", count, DEPTH + 2);
    drain();
    chk("full2_drained", count, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
